// File: rtl/w0rm_pkg.sv
// Shared constants and types for the W0RM core branch unit: condition codes,
// ALU flag layout and the output-register state encoding.
package w0rm_pkg;

   localparam int FLAGS_WIDTH = 4;

   // Bit positions of the ALU flags inside a packed {Z,N,C,V} flag vector
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [3:0] COND_EQ = 4'd0;
   localparam logic [3:0] COND_NE = 4'd1;
   localparam logic [3:0] COND_CS = 4'd2;
   localparam logic [3:0] COND_CC = 4'd3;
   localparam logic [3:0] COND_MI = 4'd4;
   localparam logic [3:0] COND_PL = 4'd5;
   localparam logic [3:0] COND_VS = 4'd6;
   localparam logic [3:0] COND_VC = 4'd7;
   localparam logic [3:0] COND_HI = 4'd8;
   localparam logic [3:0] COND_LS = 4'd9;
   localparam logic [3:0] COND_GE = 4'd10;
   localparam logic [3:0] COND_LT = 4'd11;
   localparam logic [3:0] COND_GT = 4'd12;
   localparam logic [3:0] COND_LE = 4'd13;
   localparam logic [3:0] COND_AL = 4'd14;
   localparam logic [3:0] COND_NV = 4'd15;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } bu_state_e;

endpackage

// File: rtl/w0rm_core_branch_unit_if.sv
// Instruction-in / result-out bus of the branch unit. The unit side uses the
// slave modport, the pipeline (or bench) side uses the master modport.
interface w0rm_core_branch_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 1
);
   // Handshake: an instruction is accepted on a rising edge where
   // data_valid && branch_ready; a result is consumed on a rising edge where
   // branch_valid && mem_ready. Neither valid may depend on its own ready.
   logic                  data_valid;
   logic                  branch_ready;
   logic                  is_branch;
   logic                  is_cond_branch;
   logic [3:0]            cond_branch_code;
   logic                  alu_flag_zero;
   logic                  alu_flag_negative;
   logic                  alu_flag_carry;
   logic                  alu_flag_overflow;
   logic [DATA_WIDTH-1:0] branch_base_addr;
   logic                  branch_rel_abs;
   logic [DATA_WIDTH-1:0] rn;
   logic [DATA_WIDTH-1:0] lit;
   logic [USER_WIDTH-1:0] user_data_in;

   logic                  mem_ready;
   logic                  branch_valid;
   logic                  flush_pipeline;
   logic [DATA_WIDTH-1:0] next_pc;
   logic                  next_pc_valid;
   logic [USER_WIDTH-1:0] user_data_out;

   modport master (
      output data_valid, is_branch, is_cond_branch, cond_branch_code,
             alu_flag_zero, alu_flag_negative, alu_flag_carry, alu_flag_overflow,
             branch_base_addr, branch_rel_abs, rn, lit, user_data_in, mem_ready,
      input  branch_ready, branch_valid, flush_pipeline, next_pc, next_pc_valid,
             user_data_out
   );

   modport slave (
      input  data_valid, is_branch, is_cond_branch, cond_branch_code,
             alu_flag_zero, alu_flag_negative, alu_flag_carry, alu_flag_overflow,
             branch_base_addr, branch_rel_abs, rn, lit, user_data_in, mem_ready,
      output branch_ready, branch_valid, flush_pipeline, next_pc, next_pc_valid,
             user_data_out
   );

endinterface

// File: rtl/w0rm_cond_eval.sv
// Condition-code evaluator: maps a 4-bit code and the {Z,N,C,V} flags to a
// single "condition holds" bit.
module w0rm_cond_eval
   import w0rm_pkg::*;
(
   input  logic [3:0]             cond_code_i,
   input  logic [FLAGS_WIDTH-1:0] flags_i,
   output logic                   cond_true_o
);

   logic z, n, c, v;

   assign z = flags_i[FLAG_Z];
   assign n = flags_i[FLAG_N];
   assign c = flags_i[FLAG_C];
   assign v = flags_i[FLAG_V];

   always_comb begin
      cond_true_o = 1'b0;
      case (cond_code_i)
         COND_EQ: cond_true_o = z;
         COND_NE: cond_true_o = !z;
         COND_CS: cond_true_o = c;
         COND_CC: cond_true_o = !c;
         COND_MI: cond_true_o = n;
         COND_PL: cond_true_o = !n;
         COND_VS: cond_true_o = v;
         COND_VC: cond_true_o = !v;
         COND_HI: cond_true_o = c && !z;
         COND_LS: cond_true_o = !c || z;
         COND_GE: cond_true_o = (n == v);
         COND_LT: cond_true_o = (n != v);
         COND_GT: cond_true_o = !z && (n == v);
         COND_LE: cond_true_o = z || (n != v);
         COND_AL: cond_true_o = 1'b1;
         COND_NV: cond_true_o = 1'b0;
         default: cond_true_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/w0rm_core_branch_unit.sv
// Branch resolution stage: evaluates the condition, computes the target and
// hands {taken, target, user} downstream through a one-entry result register.
module w0rm_core_branch_unit
   import w0rm_pkg::*;
#(
   parameter bit SINGLE_CYCLE = 1'b0,
   parameter int DATA_WIDTH   = 32,
   parameter int USER_WIDTH   = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   w0rm_core_branch_unit_if.slave    bus,
   output bu_state_e                 dbg_state_o
);

   logic [FLAGS_WIDTH-1:0] flags;
   logic                   cond_true;
   logic                   taken;
   logic [DATA_WIDTH-1:0]  operand;
   logic [DATA_WIDTH-1:0]  target;

   assign flags = {bus.alu_flag_zero, bus.alu_flag_negative,
                   bus.alu_flag_carry, bus.alu_flag_overflow};

   w0rm_cond_eval u_cond_eval (
      .cond_code_i (bus.cond_branch_code),
      .flags_i     (flags),
      .cond_true_o (cond_true)
   );

   assign taken   = bus.is_branch && (!bus.is_cond_branch || cond_true);
   assign operand = bus.rn + bus.lit;
   assign target  = bus.branch_rel_abs ? (bus.branch_base_addr + operand) : operand;

   if (SINGLE_CYCLE == 1'b0) begin : g_reg
      bu_state_e             state_q, state_d;
      logic                  taken_q, taken_d;
      logic [DATA_WIDTH-1:0] next_pc_q, next_pc_d;
      logic [USER_WIDTH-1:0] user_q, user_d;
      logic                  accept;

      assign accept = bus.data_valid && bus.branch_ready;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q   <= ST_EMPTY;
            taken_q   <= 1'b0;
            next_pc_q <= '0;
            user_q    <= '0;
         end else begin
            state_q   <= state_d;
            taken_q   <= taken_d;
            next_pc_q <= next_pc_d;
            user_q    <= user_d;
         end
      end

      // A consume and a new accept in the same cycle simply reload the entry
      always_comb begin
         state_d   = state_q;
         taken_d   = taken_q;
         next_pc_d = next_pc_q;
         user_d    = user_q;
         case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL: begin
               if (accept)             state_d = ST_FULL;
               else if (bus.mem_ready) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
         endcase
         if (accept) begin
            taken_d   = taken;
            next_pc_d = target;
            user_d    = bus.user_data_in;
         end else if (state_q == ST_FULL && bus.mem_ready) begin
            taken_d = 1'b0;
         end
      end

      always_comb begin
         bus.branch_ready   = (state_q == ST_EMPTY) || bus.mem_ready;
         bus.branch_valid   = (state_q == ST_FULL);
         bus.flush_pipeline = (state_q == ST_FULL) && taken_q;
         bus.next_pc_valid  = (state_q == ST_FULL) && taken_q;
         bus.next_pc        = next_pc_q;
         bus.user_data_out  = user_q;
         dbg_state_o        = state_q;
      end
   end else begin : g_comb
      always_comb begin
         bus.branch_ready   = bus.mem_ready;
         bus.branch_valid   = bus.data_valid;
         bus.flush_pipeline = bus.data_valid && taken;
         bus.next_pc_valid  = bus.data_valid && taken;
         bus.next_pc        = target;
         bus.user_data_out  = bus.user_data_in;
         dbg_state_o        = bus.data_valid ? ST_FULL : ST_EMPTY;
      end
   end

endmodule

// File: tb/tb_w0rm_core_branch_unit.sv
// Bench for the branch unit: vector table, 16x16 condition sweep under random
// backpressure, plus hold and asynchronous-reset sequences.
module tb_w0rm_core_branch_unit;
   import w0rm_pkg::*;

   localparam int DW    = 32;
   localparam int EXP_W = 1 + 1 + DW + 1;

   typedef struct {
      logic          is_br;
      logic          is_cond;
      logic [3:0]    code;
      logic [3:0]    flags;   // {Z,N,C,V}
      logic          rel;
      logic [DW-1:0] base;
      logic [DW-1:0] rn;
      logic [DW-1:0] lit;
      logic [0:0]    user;
      logic          exp_taken;
      logic [DW-1:0] exp_pc;
   } vec_t;

   logic             clk;
   logic             reset;
   bu_state_e        dbg_state;
   logic             rand_bp;
   logic             mem_ready_set;
   logic [EXP_W-1:0] cur_exp;
   logic [EXP_W-1:0] exp_q[$];
   int               tests;
   int               errs;
   vec_t             vecs[10];

   w0rm_core_branch_unit_if #(.DATA_WIDTH(DW), .USER_WIDTH(1)) bus ();

   w0rm_core_branch_unit #(.SINGLE_CYCLE(1'b0), .DATA_WIDTH(DW), .USER_WIDTH(1)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1 bus.mem_ready = rand_bp ? 1'($urandom_range(0, 1)) : mem_ready_set;
   end

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      logic [EXP_W-1:0] got, e;
      if (!reset) begin
         if (bus.branch_valid && bus.mem_ready) begin
            tests++;
            got = {bus.flush_pipeline, bus.next_pc_valid, bus.next_pc, bus.user_data_out};
            if (exp_q.size() == 0) begin
               errs++;
               $display("FAIL sb_unexpected: got %h, required nothing pending", got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  errs++;
                  $display("FAIL sb_result: got {flush,npv,pc,user}=%h, required %h", got, e);
               end
            end
         end
         if (bus.data_valid && bus.branch_ready) exp_q.push_back(cur_exp);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic present(input vec_t v);
      @(posedge clk);
      #1;
      bus.is_branch         = v.is_br;
      bus.is_cond_branch    = v.is_cond;
      bus.cond_branch_code  = v.code;
      bus.alu_flag_zero     = v.flags[3];
      bus.alu_flag_negative = v.flags[2];
      bus.alu_flag_carry    = v.flags[1];
      bus.alu_flag_overflow = v.flags[0];
      bus.branch_rel_abs    = v.rel;
      bus.branch_base_addr  = v.base;
      bus.rn                = v.rn;
      bus.lit               = v.lit;
      bus.user_data_in      = v.user;
      cur_exp               = {v.exp_taken, v.exp_taken, v.exp_pc, v.user};
      bus.data_valid        = 1'b1;
   endtask

   task automatic send(input vec_t v);
      bit done;
      done = 0;
      present(v);
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (bus.branch_ready) done = 1;
      end
      if (!done) begin
         tests++;
         errs++;
         $display("FAIL send_timeout: got branch_ready=0 for 200 cycles, required 1");
         bus.data_valid = 1'b0;
      end
   endtask

   task automatic drain();
      @(posedge clk);
      #1 bus.data_valid = 1'b0;
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic model_cond(input logic [3:0] code, input logic [3:0] f);
      logic z, n, c, v, b;
      {z, n, c, v} = f;
      case (code[3:1])
         3'd0: b = z;
         3'd1: b = c;
         3'd2: b = n;
         3'd3: b = v;
         3'd4: b = c & ~z;
         3'd5: b = ~(n ^ v);
         3'd6: b = ~z & ~(n ^ v);
         default: b = 1'b1;
      endcase
      return b ^ code[0];
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      vec_t v;
      logic [DW-1:0] hold_pc;
      tests = 0;
      errs  = 0;
      rand_bp = 1'b0;
      mem_ready_set = 1'b1;
      cur_exp = '0;
      bus.mem_ready = 1'b1;
      bus.data_valid = 1'b0;
      bus.is_branch = 1'b0; bus.is_cond_branch = 1'b0; bus.cond_branch_code = 4'd0;
      bus.alu_flag_zero = 1'b0; bus.alu_flag_negative = 1'b0;
      bus.alu_flag_carry = 1'b0; bus.alu_flag_overflow = 1'b0;
      bus.branch_rel_abs = 1'b0; bus.branch_base_addr = '0;
      bus.rn = '0; bus.lit = '0; bus.user_data_in = '0;

      //             br cond code   flags  rel  base          rn            lit           usr  tkn  pc
      vecs[0] = '{1, 0, 4'd0,  4'b0000, 0, 32'h0,        32'h100,      32'h20,       1'b0, 1, 32'h120};
      vecs[1] = '{1, 0, 4'd0,  4'b0000, 1, 32'hFFFFFFF0, 32'h0,        32'h20,       1'b1, 1, 32'h10};
      vecs[2] = '{1, 1, 4'd0,  4'b0000, 0, 32'h0,        32'h200,      32'h4,        1'b0, 0, 32'h204};
      vecs[3] = '{1, 1, 4'd0,  4'b1000, 0, 32'h0,        32'h200,      32'h4,        1'b1, 1, 32'h204};
      vecs[4] = '{0, 0, 4'd14, 4'b0000, 0, 32'h0,        32'h10,       32'h10,       1'b0, 0, 32'h20};
      vecs[5] = '{1, 0, 4'd0,  4'b0000, 1, 32'h1000,     32'h8,        32'hFFFFFFF0, 1'b1, 1, 32'h0FF8};
      vecs[6] = '{1, 0, 4'd0,  4'b0000, 0, 32'h0,        32'hFFFFFFFF, 32'h2,        1'b0, 1, 32'h1};
      vecs[7] = '{1, 1, 4'd12, 4'b0101, 1, 32'h40,       32'h4,        32'h4,        1'b0, 1, 32'h48};
      vecs[8] = '{1, 1, 4'd11, 4'b0100, 0, 32'h0,        32'h300,      32'h0,        1'b1, 1, 32'h300};
      vecs[9] = '{1, 1, 4'd15, 4'b1111, 1, 32'h10,       32'h1,        32'h1,        1'b0, 0, 32'h12};

      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_branch_valid", 64'(bus.branch_valid), 64'd0);
      check("rst_flush", 64'(bus.flush_pipeline), 64'd0);
      check("rst_next_pc_valid", 64'(bus.next_pc_valid), 64'd0);
      check("rst_next_pc", 64'(bus.next_pc), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(ST_EMPTY));
      reset = 1'b0;
      @(negedge clk);
      check("rst_branch_ready", 64'(bus.branch_ready), 64'd1);

      // Vector table, back-to-back at full throughput
      foreach (vecs[i]) send(vecs[i]);
      drain();

      // Condition sweep under random backpressure
      rand_bp = 1'b1;
      for (int code = 0; code < 16; code++) begin
         for (int f = 0; f < 16; f++) begin
            v.is_br = 1'b1; v.is_cond = 1'b1;
            v.code = 4'(code); v.flags = 4'(f);
            v.rel = 1'b0; v.base = '0;
            v.rn = $urandom; v.lit = $urandom;
            v.user = 1'($urandom_range(0, 1));
            v.exp_taken = model_cond(4'(code), 4'(f));
            v.exp_pc = v.rn + v.lit;
            send(v);
         end
      end
      rand_bp = 1'b0;
      mem_ready_set = 1'b1;
      drain();

      // Backpressure hold: result A must stay put while B waits
      mem_ready_set = 1'b0;
      @(posedge clk);
      send(vecs[0]);
      hold_pc = vecs[0].exp_pc;
      present(vecs[6]);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_branch_ready", 64'(bus.branch_ready), 64'd0);
         check("hold_branch_valid", 64'(bus.branch_valid), 64'd1);
         check("hold_next_pc", 64'(bus.next_pc), 64'(hold_pc));
         check("hold_flush", 64'(bus.flush_pipeline), 64'd1);
      end
      check("hold_state", 64'(dbg_state), 64'(ST_FULL));
      check("hold_queue_depth", 64'(exp_q.size()), 64'd1);
      mem_ready_set = 1'b1;
      @(negedge clk);
      check("release_branch_ready", 64'(bus.branch_ready), 64'd1);
      drain();

      // Asynchronous reset while a result is held
      mem_ready_set = 1'b0;
      @(posedge clk);
      send(vecs[5]);
      @(posedge clk);
      #1 bus.data_valid = 1'b0;
      #2 reset = 1'b1;
      exp_q.delete();
      #1;
      check("arst_branch_valid", 64'(bus.branch_valid), 64'd0);
      check("arst_flush", 64'(bus.flush_pipeline), 64'd0);
      check("arst_next_pc_valid", 64'(bus.next_pc_valid), 64'd0);
      check("arst_next_pc", 64'(bus.next_pc), 64'd0);
      check("arst_user", 64'(bus.user_data_out), 64'd0);
      @(posedge clk);
      #2 reset = 1'b0;
      mem_ready_set = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("arst_branch_ready", 64'(bus.branch_ready), 64'd1);
      check("arst_no_result", 64'(bus.branch_valid), 64'd0);

      // One more transaction after reset to confirm normal operation resumes
      send(vecs[7]);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish, required finish before 2ms");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/w0rm_core_branch_unit.md
Name: w0rm_core_branch_unit

Overview:
Branch resolution stage of the W0RM core execute path.
- Accepts one decoded instruction per handshake.
- Evaluates an optional 4-bit condition code against the ALU flags (Z/N/C/V).
- Computes an absolute or PC-relative target.
- Reports branch result, pipeline flush and next PC to the fetch/memory stage, with a one-entry output register and a ready/valid handshake.

Parameters:
- SINGLE_CYCLE, 0: 0 = registered outputs (1-cycle latency); 1 = combinational result path, same cycle as accept.
- DATA_WIDTH, 32: address/data width.
- USER_WIDTH, 1: width of sideband user data carried alongside the instruction.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_ready  in  1  downstream may consume the result this cycle.
- branch_ready  out  1  unit can accept an instruction this cycle.
- data_valid  in  1  instruction inputs valid.
- is_branch  in  1  instruction is a branch.
- is_cond_branch  in  1  branch is conditional.
- cond_branch_code  in  4  condition code.
- alu_flag_zero  in  1  Z flag.
- alu_flag_negative  in  1  N flag.
- alu_flag_carry  in  1  C flag.
- alu_flag_overflow  in  1  V flag.
- branch_base_addr  in  DATA_WIDTH  PC of the branch instruction.
- branch_rel_abs  in  1  1 = relative target, 0 = absolute target.
- rn  in  DATA_WIDTH  register operand.
- lit  in  DATA_WIDTH  sign-extended literal operand.
- branch_valid  out  1  result register holds a result.
- flush_pipeline  out  1  branch taken; younger instructions must be discarded.
- next_pc  out  DATA_WIDTH  branch target.
- next_pc_valid  out  1  next_pc must be loaded into the PC.
- user_data_in  in  USER_WIDTH  sideband input.
- user_data_out  out  USER_WIDTH  sideband output, aligned with branch_valid.

Behaviour:
- Handshake:
  - branch_ready = !out_valid || mem_ready (combinational).
  - accept = data_valid && branch_ready.
- Condition evaluation (cond_true):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V).
  - 14 AL 1; 15 NV 0.
- taken = is_branch && (!is_cond_branch || cond_true). Non-branch instructions are never taken.
- Target computation:
  - operand = rn + lit, modulo 2^DATA_WIDTH.
  - target = branch_rel_abs ? branch_base_addr + operand : operand, wrap-around, no overflow detection.
- SINGLE_CYCLE=0:
  - On accept, the output register loads taken → flush_pipeline and next_pc_valid, target → next_pc, user_data_in → user_data_out, and sets out_valid=1.
  - branch_valid = out_valid.
  - Outputs hold stable while out_valid && !mem_ready.
  - When mem_ready=1 and no new accept, out_valid clears and flush_pipeline/next_pc_valid clear. next_pc and user_data_out keep their last value.
  - Simultaneous consume and accept: register reloads, out_valid stays 1, giving back-to-back throughput of 1/cycle.
- SINGLE_CYCLE=1:
  - Outputs are driven combinationally from inputs, gated by data_valid.
  - branch_ready = mem_ready.
- Reset (async, any time, including mid-hold):
  - out_valid, branch_valid, flush_pipeline and next_pc_valid go to 0.
  - next_pc and user_data_out go to 0.
  - A pending result is dropped.
- next_pc_valid and flush_pipeline are never 1 while branch_valid is 0.

Decomposition:
- Shared package w0rm_pkg:
  - Condition-code constants COND_EQ..COND_NV (4-bit).
  - Flag-width constant FLAGS_WIDTH=4.
- Sub-module w0rm_cond_eval: combinational 4-bit code + 4 flags → cond_true.

Test Plan:
- Unconditional absolute: is_branch=1, is_cond=0, rel_abs=0, rn=0x100, lit=0x20 → next cycle branch_valid=1, next_pc_valid=1, flush=1, next_pc=0x120.
- Relative wrap: rel_abs=1, base=0xFFFFFFF0, rn=0, lit=0x20 → next_pc=0x00000010, taken.
- Conditional not taken: is_cond=1, code=0 (EQ), Z=0 → branch_valid=1, next_pc_valid=0, flush=0. Same with Z=1 → taken.
- Condition sweep: all 16 codes × 16 flag combinations → taken matches the table; code 15 never taken, code 14 always taken.
- Backpressure: mem_ready=0 with a result held → branch_ready=0, outputs stable for 5 cycles, a new data_valid is not accepted; mem_ready=1 → consumed, branch_ready=1.
- Reset mid-hold: result pending, assert reset asynchronously → all valid/flush outputs 0 immediately, next_pc=0, branch_ready=1 after release.
